// File: rtl/alu_op_seq.sv
// alu_op_seq: operation sequencer and result register around the ALU result mux.
// Accepts one operation per valid/ready handshake. It drives operands and unit
// selects to the external logic, shifter and add/sub units. It then captures the
// mux output as the result. Multi-bit shifts are built by feeding the 1-bit
// shifter output back into operand A once per cycle.
module alu_op_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] opa_out,
    output logic [WIDTH-1:0] opb_out,
    output logic [1:0]       logic_op,
    output logic [1:0]       shift_op,
    output logic             add_sub_sel,
    input  logic             add_sub_cout,
    output logic [1:0]       ar_mux_en,
    input  logic [WIDTH-1:0] ar_mux_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    logic w_in_is_shift;
    logic w_op_logic;
    logic w_op_addsub;
    logic w_op_illegal;
    logic w_cnt_zero;

    // The opcode class of the incoming request selects the first working state.
    assign w_in_is_shift = (opcode[3:2] == 2'b01);

    // Class decode of the latched operation.
    assign w_op_logic   = (r_op[3:2] == 2'b00);
    assign w_op_addsub  = (r_op[3:1] == 3'b100);
    assign w_op_illegal = !w_op_logic && !w_op_addsub && (r_op[3:2] != 2'b01);
    assign w_cnt_zero   = (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, handshake ready and mux select.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        ar_mux_en    = 2'b00;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_in_is_shift ? S_SHIFT : S_EXEC;
                end
            end
            S_EXEC: begin
                // Illegal opcodes leave the select at 00, so the mux yields zero.
                if (w_op_logic) begin
                    ar_mux_en = 2'b01;
                end else if (w_op_addsub) begin
                    ar_mux_en = 2'b11;
                end
                w_state_next = S_DONE;
            end
            S_SHIFT: begin
                if (!w_cnt_zero) begin
                    ar_mux_en = 2'b10;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand, decode, count, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_out     <= '0;
            opb_out     <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            logic_op    <= 2'b00;
            shift_op    <= 2'b00;
            add_sub_sel <= 1'b0;
            result      <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_c      <= 1'b0;
            flag_err    <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        opa_out     <= opa;
                        opb_out     <= opb;
                        r_op        <= opcode;
                        r_cnt       <= opb[CNT_W-1:0];
                        logic_op    <= opcode[1:0];
                        shift_op    <= opcode[1:0];
                        add_sub_sel <= opcode[0];
                    end
                end
                S_EXEC: begin
                    result    <= ar_mux_in;
                    flag_z    <= (ar_mux_in == '0);
                    flag_n    <= ar_mux_in[WIDTH-1];
                    flag_c    <= w_op_addsub ? add_sub_cout : 1'b0;
                    flag_err  <= w_op_illegal;
                    res_valid <= 1'b1;
                end
                S_SHIFT: begin
                    if (!w_cnt_zero) begin
                        // The shifter output becomes the next operand A.
                        opa_out <= ar_mux_in;
                        r_cnt   <= r_cnt - 1'b1;
                    end else begin
                        result    <= opa_out;
                        flag_z    <= (opa_out == '0);
                        flag_n    <= opa_out[WIDTH-1];
                        flag_c    <= 1'b0;
                        flag_err  <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_seq.sv
// tb_alu_op_seq: scoreboard bench for alu_op_seq with behavioural external units.
module tb_alu_op_seq;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  opa_out;
    logic [W-1:0]  opb_out;
    logic [1:0]    logic_op;
    logic [1:0]    shift_op;
    logic          add_sub_sel;
    logic          add_sub_cout;
    logic [1:0]    ar_mux_en;
    logic [W-1:0]  ar_mux_in;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  result;
    logic          flag_z;
    logic          flag_n;
    logic          flag_c;
    logic          flag_err;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   en_cnt[4];

    alu_op_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .opa          (opa),
        .opb          (opb),
        .opa_out      (opa_out),
        .opb_out      (opb_out),
        .logic_op     (logic_op),
        .shift_op     (shift_op),
        .add_sub_sel  (add_sub_sel),
        .add_sub_cout (add_sub_cout),
        .ar_mux_en    (ar_mux_en),
        .ar_mux_in    (ar_mux_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .result       (result),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_c       (flag_c),
        .flag_err     (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External logic, shifter and add/sub units, plus the result mux.
    always_comb begin
        logic [W:0] s;
        s            = '0;
        ar_mux_in    = '0;
        add_sub_cout = 1'b0;
        s = add_sub_sel ? ({1'b0, opa_out} - {1'b0, opb_out})
                        : ({1'b0, opa_out} + {1'b0, opb_out});
        add_sub_cout = s[W];
        case (ar_mux_en)
            2'b01: case (logic_op)
                2'b00:   ar_mux_in = opa_out & opb_out;
                2'b01:   ar_mux_in = opa_out | opb_out;
                2'b10:   ar_mux_in = opa_out ^ opb_out;
                default: ar_mux_in = ~opa_out;
            endcase
            2'b10: case (shift_op)
                2'b00:   ar_mux_in = {opa_out[W-2:0], 1'b0};
                2'b01:   ar_mux_in = {1'b0, opa_out[W-1:1]};
                2'b10:   ar_mux_in = {opa_out[W-1], opa_out[W-1:1]};
                default: ar_mux_in = {opa_out[W-2:0], opa_out[W-1]};
            endcase
            2'b11:   ar_mux_in = s[W-1:0];
            default: ar_mux_in = '0;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-operation reference: multi-bit shifts computed directly.
    function automatic exp_t ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] v;
        logic [W:0]   s;
        e = '0;
        v = '0;
        s = '0;
        case (op)
            4'h0: v = a & b;
            4'h1: v = a | b;
            4'h2: v = a ^ b;
            4'h3: v = ~a;
            4'h4: v = a << b[3:0];
            4'h5: v = a >> b[3:0];
            4'h6: v = W'($signed(a) >>> b[3:0]);
            4'h7: v = (b[3:0] == 4'd0) ? a : W'((a << b[3:0]) | (a >> (W - int'(b[3:0]))));
            4'h8: begin s = {1'b0, a} + {1'b0, b}; v = s[W-1:0]; e.c = s[W]; end
            4'h9: begin v = a - b; e.c = (a < b); end
            default: begin v = '0; e.err = 1'b1; end
        endcase
        e.res = v;
        e.z   = (v == '0);
        e.n   = v[W-1];
        return e;
    endfunction

    // Count cycles per mux select, and compare each result at its handshake.
    always @(negedge clk) begin
        exp_t e;
        en_cnt[ar_mux_en] = en_cnt[ar_mux_en] + 1;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_result", 32'(result), 32'hDEAD);
            end else begin
                e = sb.pop_front();
                $display("result op -> %04h z%0d n%0d c%0d e%0d", result, flag_z, flag_n, flag_c, flag_err);
                check_val("result",   32'(result),   32'(e.res));
                check_val("flag_z",   32'(flag_z),   32'(e.z));
                check_val("flag_n",   32'(flag_n),   32'(e.n));
                check_val("flag_c",   32'(flag_c),   32'(e.c));
                check_val("flag_err", 32'(flag_err), 32'(e.err));
            end
        end
    end

    // Drive one request and hold it through the accepting edge.
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        opcode   = op;
        opa      = a;
        opb      = b;
        sb.push_back(ref_model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for res_valid with a bound and check the edge count since accept.
    task automatic wait_res(input int exp_lat);
        int lat;
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (res_valid || lat > 40) break;
        end
        check_val("latency", 32'(lat), 32'(exp_lat));
    endtask

    // Full operation with res_ready high: latency and mux-select cycle counts.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int e1, e2, e3, lat;
        logic is_logic, is_shift, is_as;
        is_logic = (op[3:2] == 2'b00);
        is_shift = (op[3:2] == 2'b01);
        is_as    = (op == 4'h8) || (op == 4'h9);
        lat      = is_shift ? int'(b[3:0]) + 1 : 1;
        $display("op %h a=%04h b=%04h", op, a, b);
        start_op(op, a, b);
        e1 = en_cnt[1]; e2 = en_cnt[2]; e3 = en_cnt[3];
        wait_res(lat);
        @(posedge clk);
        #1;
        check_val("en01_cycles", 32'(en_cnt[1] - e1), is_logic ? 32'd1 : 32'd0);
        check_val("en10_cycles", 32'(en_cnt[2] - e2), is_shift ? 32'(b[3:0]) : 32'd0);
        check_val("en11_cycles", 32'(en_cnt[3] - e3), is_as ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        opa       = '0;
        opb       = '0;
        res_ready = 1'b1;
        #12;
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_result",    32'(result),    32'd0);
        check_val("rst_opa_out",   32'(opa_out),   32'd0);
        check_val("rst_flags",     32'({flag_z, flag_n, flag_c, flag_err}), 32'd0);
        check_val("rst_mux_en",    32'(ar_mux_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'h0, 16'h00F0, 16'h0FF0);   // AND
        run_op(4'h8, 16'hFFFF, 16'h0001);   // ADD carry, zero
        run_op(4'h9, 16'h0001, 16'h0002);   // SUB borrow, negative
        run_op(4'h4, 16'h0001, 16'h0005);   // SHL by 5
        run_op(4'h6, 16'h8000, 16'h0003);   // SAR by 3
        run_op(4'h5, 16'hABCD, 16'h0010);   // shift count 0 from low bits
        run_op(4'hB, 16'h1234, 16'h5678);   // illegal
        run_op(4'h1, 16'h1200, 16'h0034);   // OR clears err
        run_op(4'h2, 16'hFF00, 16'h0FF0);   // XOR
        run_op(4'h3, 16'h00FF, 16'h1234);   // NOT A
        run_op(4'h7, 16'h8001, 16'h0004);   // ROL by 4
        run_op(4'h5, 16'h8000, 16'h000F);   // SHR by 15

        for (int i = 0; i < 8; i++) begin
            run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        // Backpressure: result held, requests ignored while in DONE.
        res_ready = 1'b0;
        $display("op 8 a=1234 b=1111 held");
        start_op(4'h8, 16'h1234, 16'h1111);
        wait_res(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            opcode   = 4'h3;
            opa      = 16'h5555;
            check_val("bp_in_ready",  32'(in_ready),  32'd0);
            check_val("bp_res_valid", 32'(res_valid), 32'd1);
            check_val("bp_result",    32'(result),    32'h2345);
            check_val("bp_flags",     32'({flag_z, flag_n, flag_c, flag_err}), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_in_ready", 32'(in_ready),  32'd1);
        check_val("bp_release_valid",    32'(res_valid), 32'd0);

        // Asynchronous reset in the middle of a 7-step shift.
        $display("op 4 a=0001 b=0007 reset mid-shift");
        start_op(4'h4, 16'h0001, 16'h0007);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_val("arst_in_ready",  32'(in_ready),  32'd1);
        check_val("arst_opa_out",   32'(opa_out),   32'd0);
        check_val("arst_result",    32'(result),    32'd0);
        check_val("arst_res_valid", 32'(res_valid), 32'd0);
        check_val("arst_mux_en",    32'(ar_mux_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'h8, 16'h7FFF, 16'h0001);

        repeat (3) @(posedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_seq.md
Name: alu_op_seq

Overview:
- Operation sequencer and result register that sits directly upstream and downstream of the ALU result multiplexer.
- Accepts one ALU operation per valid/ready handshake and latches the operands.
- Drives the operand buses and unit selects (logic, shifter, add/sub) plus the 2-bit mux select `ar_mux_en`.
- Consumes the mux output: registers the result with flags, or iterates it back as operand A for multi-bit shifts using the 1-bit-per-cycle shifter unit.

Parameters:
- WIDTH, 16, datapath width of operands, mux input and result.
- CNT_W, 4, width of shift count taken from `opb[CNT_W-1:0]`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  sequencer can accept an operation.
- opcode  in  4  operation code.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B.
- opa_out  out  WIDTH  registered operand A to all units.
- opb_out  out  WIDTH  registered operand B to all units.
- logic_op  out  2  logic unit function: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- shift_op  out  2  shifter function, 1-bit shift: 00 SHL, 01 SHR logical, 10 SAR, 11 ROL.
- add_sub_sel  out  1  0 add, 1 subtract.
- add_sub_cout  in  1  carry/borrow-out of the add/sub unit.
- ar_mux_en  out  2  mux select: 01 logic, 10 shifter, 11 add/sub, 00 forces mux output to 0.
- ar_mux_in  in  WIDTH  mux output.
- res_valid  out  1  result and flags valid.
- res_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry; nonzero only for ADD/SUB.
- flag_err  out  1  illegal opcode.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low (`rst_n`).
- Reset values: state IDLE; all registered outputs 0 (opa_out, opb_out, result, all flags, res_valid, internal count); in_ready = 1.
- Opcode map:
  - 0x0-0x3 logic, logic_op = opcode[1:0].
  - 0x4-0x7 shift, shift_op = opcode[1:0].
  - 0x8 ADD, 0x9 SUB, add_sub_sel = opcode[0].
  - 0xA-0xF illegal.
- logic_op, shift_op and add_sub_sel are registered decodes of the accepted opcode and hold until the next accept.
- States: IDLE, EXEC, SHIFT, DONE.
- in_ready = (state == IDLE), combinational.
- ar_mux_en = 00 in IDLE and DONE.
- IDLE: on in_valid & in_ready:
  - latch opa, opb, opcode into opa_out, opb_out, op register;
  - load cnt = opb[CNT_W-1:0];
  - go to SHIFT if shift opcode, else EXEC.
  - in_valid without ready is ignored; inputs are not sampled.
- EXEC (one cycle):
  - ar_mux_en = 01 or 11 per opcode class; 00 for illegal.
  - On the edge: result <= ar_mux_in.
  - flag_c <= add_sub_cout for ADD/SUB, else 0.
  - flag_err <= illegal.
  - flag_z and flag_n are derived from the captured value.
  - res_valid <= 1; go to DONE.
  - Logic/add latency: res_valid is high after the first edge following the accept edge.
- SHIFT:
  - If cnt != 0: ar_mux_en = 10; on the edge opa_out <= ar_mux_in and cnt <= cnt - 1.
  - If cnt == 0: ar_mux_en = 00; on the edge result <= opa_out, flags updated (flag_c = 0, flag_err = 0), res_valid <= 1, go to DONE.
  - Shift-by-n latency is n+1 edges after accept; shift by 0 returns A unchanged after 1 edge.
- DONE: result and flags stable while res_valid = 1. On res_ready, res_valid <= 0 and go to IDLE. A new accept is possible in the following cycle; there is no IDLE bypass.
- Flags and result hold their values after DONE until the next capture.
- res_ready outside DONE is ignored.
- Reset asserted mid-operation: immediate return to reset values and IDLE; the partial shift is discarded.
- Arithmetic is performed entirely in external units; this block does no arithmetic except the cnt decrement, which never wraps because it stops at 0.

Test Plan:
- AND 0x00F0 & 0x0FF0 (opcode 0x0), res_ready = 1 → ar_mux_en = 01 for one cycle; result 0x00F0, Z = 0, N = 0, C = 0, res_valid 1 edge after accept.
- ADD 0xFFFF + 0x0001 with model add unit → result 0x0000, Z = 1, C = 1; SUB 0x0001 - 0x0002 → result 0xFFFF, N = 1.
- SHL 0x0001 by opb = 5 → ar_mux_en = 10 for exactly 5 cycles, result 0x0020 after 6 edges; SAR 0x8000 by 3 → 0xF000, N = 1; shift by 0 → result = A after 1 edge, ar_mux_en never 10.
- Opcode 0xB → ar_mux_en = 00, result 0, flag_err = 1, Z = 1; next legal op clears flag_err.
- Backpressure: hold res_ready = 0 for 10 cycles → result/flags stable, in_ready = 0, in_valid pulses ignored; then res_ready = 1 → IDLE, in_ready = 1.
- Assert rst_n low during a SHIFT with cnt = 7 → asynchronous clear: outputs 0, in_ready = 1; a following ADD completes correctly.
